// File: rtl/bitplane_serializer.sv
// Bit-plane serializer: reads a DEPTH-word bank once per bit plane and
// streams each plane as a PW-bit header (plane index) plus DEPTH data bits.
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   start            one-cycle request, accepted only when idle
//   sready           downstream ready; low stalls the header/data stream
//   RB_RW, RB_A      bank control (always read), bank address
//   RB_Q             bank read data, combinational from RB_A
//   sen, sd          serial strobe (active-low) and data, registered
//   busy, done       activity flag and end-of-job pulse
module bitplane_serializer #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 18,
    parameter int MSB_FIRST = 1,
    parameter int AW        = $clog2(DEPTH),
    parameter int PW        = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sready,
    output logic              RB_RW,
    output logic [AW-1:0]     RB_A,
    input  logic [DATA_W-1:0] RB_Q,
    output logic              sen,
    output logic              sd,
    output logic              busy,
    output logic              done
);
    // One spare bit beyond the widest count keeps the shared counter
    // from wrapping for any DEPTH or header length.
    localparam int CW = ((AW > PW) ? AW : PW) + 1;
    localparam logic [CW-1:0] LAST_J  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] LAST_H  = CW'(PW - 1);
    localparam logic [PW-1:0] HDR_TOP = PW'(PW - 1);
    localparam logic [PW-1:0] LAST_K  = PW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HDR,
        DATA,
        GAP,
        FIN
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic [PW-1:0]     k_q;
    logic [PW-1:0]     k_d;
    logic [DEPTH-1:0]  bits_q;
    logic [PW-1:0]     bit_sel;
    logic [PW-1:0]     hdr_pos;
    logic [PW-1:0]     hdr_shift;
    logic              cap;
    logic              emit;
    logic              emit_bit;

    assign RB_RW     = 1'b1;
    assign RB_A      = (state_q == LOAD) ? cnt_q[AW-1:0] : '0;
    assign bit_sel   = (MSB_FIRST != 0) ? (LAST_K - k_q) : k_q;
    assign hdr_pos   = HDR_TOP - cnt_q[PW-1:0];
    assign hdr_shift = k_q >> hdr_pos;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        cap      = 1'b0;
        emit     = 1'b0;
        emit_bit = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    k_d     = '0;
                end
            end
            LOAD: begin
                cap = 1'b1;
                if (cnt_q == LAST_J) begin
                    state_d = HDR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HDR: begin
                if (sready) begin
                    emit     = 1'b1;
                    emit_bit = hdr_shift[0];
                    if (cnt_q == LAST_H) begin
                        state_d = DATA;
                        cnt_d   = LAST_J;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DATA: begin
                if (sready) begin
                    emit     = 1'b1;
                    emit_bit = bits_q[cnt_q[AW-1:0]];
                    if (cnt_q == '0) begin
                        state_d = GAP;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            GAP: begin
                if (k_q == LAST_K) begin
                    state_d = FIN;
                end else begin
                    state_d = LOAD;
                    k_d     = k_q + PW'(1);
                    cnt_d   = '0;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            k_q    <= '0;
            bits_q <= '0;
            sen    <= 1'b1;
            sd     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            k_q   <= k_d;
            if (cap) begin
                bits_q[cnt_q[AW-1:0]] <= RB_Q[bit_sel];
            end
            sen  <= ~emit;
            sd   <= emit & emit_bit;
            busy <= (state_d != IDLE);
            done <= (state_d == FIN);
        end
    end

endmodule

// File: tb/tb_bitplane_serializer.sv
// Scoreboard bench for bitplane_serializer: default instance (8x18, MSB
// first) and a 16x5 LSB-first instance, each with its own expected queue.
`timescale 1ns/1ps
module tb_bitplane_serializer;
    localparam int DW  = 8;
    localparam int DP  = 18;
    localparam int PW  = 3;
    localparam int AW  = 5;
    localparam int DW2 = 16;
    localparam int DP2 = 5;
    localparam int PW2 = 4;
    localparam int AW2 = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           sready = 1'b1;
    logic           start2 = 1'b0;
    logic           sready2 = 1'b1;
    logic           rb_rw;
    logic [AW-1:0]  rb_a;
    logic [DW-1:0]  rb_q;
    logic           sen;
    logic           sd;
    logic           busy;
    logic           done;
    logic           rb_rw2;
    logic [AW2-1:0] rb_a2;
    logic [DW2-1:0] rb_q2;
    logic           sen2;
    logic           sd2;
    logic           busy2;
    logic           done2;

    logic [DW-1:0]  bank  [DP];
    logic [DW2-1:0] bank2 [DP2];

    assign rb_q  = bank[rb_a];
    assign rb_q2 = bank2[rb_a2];

    bitplane_serializer u_dut (
        .clk(clk), .rst(rst), .start(start), .sready(sready),
        .RB_RW(rb_rw), .RB_A(rb_a), .RB_Q(rb_q),
        .sen(sen), .sd(sd), .busy(busy), .done(done)
    );

    bitplane_serializer #(.DATA_W(DW2), .DEPTH(DP2), .MSB_FIRST(0)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .sready(sready2),
        .RB_RW(rb_rw2), .RB_A(rb_a2), .RB_Q(rb_q2),
        .sen(sen2), .sd(sd2), .busy(busy2), .done(done2)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic rdy_q = 1'b1;
    bit sb1[$];
    bit sb2[$];
    int bits1 = 0;
    int done1 = 0;
    int done_cyc1 = 0;
    int bits2 = 0;
    int done2n = 0;
    int done_cyc2 = 0;
    int maxa2 = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rdy_q <= sready;
    end

    always @(negedge clk) begin : mon1
        bit e;
        if (sen === 1'b0) begin
            bits1++;
            checks++;
            if (rdy_q !== 1'b1) begin
                errors++;
                $display("FAIL stall1 sen=0 got sready=%0b required 1 cyc %0d", rdy_q, cyc);
            end
            checks++;
            if (sb1.size() == 0) begin
                errors++;
                $display("FAIL extra1 got sd=%0b required no bit", sd);
            end else begin
                e = sb1.pop_front();
                if (sd !== e) begin
                    errors++;
                    $display("FAIL bit1 #%0d got %0b required %0b", bits1, sd, e);
                end
            end
        end else begin
            checks++;
            if (sd !== 1'b0) begin
                errors++;
                $display("FAIL quiet1 sd got %0b required 0", sd);
            end
        end
        if (done === 1'b1) begin
            done1++;
            done_cyc1 = cyc;
        end
    end

    always @(negedge clk) begin : mon2
        bit e;
        if (int'(rb_a2) > maxa2) maxa2 = int'(rb_a2);
        if (sen2 === 1'b0) begin
            bits2++;
            checks++;
            if (sb2.size() == 0) begin
                errors++;
                $display("FAIL extra2 got sd=%0b required no bit", sd2);
            end else begin
                e = sb2.pop_front();
                if (sd2 !== e) begin
                    errors++;
                    $display("FAIL bit2 #%0d got %0b required %0b", bits2, sd2, e);
                end
            end
        end
        if (done2 === 1'b1) begin
            done2n++;
            done_cyc2 = cyc;
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic push1();
        for (int k = 0; k < DW; k++) begin
            for (int h = PW - 1; h >= 0; h--) sb1.push_back(k[h]);
            for (int j = DP - 1; j >= 0; j--) sb1.push_back(bank[j][DW-1-k]);
        end
    endtask

    task automatic push2();
        for (int k = 0; k < DW2; k++) begin
            for (int h = PW2 - 1; h >= 0; h--) sb2.push_back(k[h]);
            for (int j = DP2 - 1; j >= 0; j--) sb2.push_back(bank2[j][k]);
        end
    endtask

    task automatic run1(input bit rnd, input bit repulse, input bit lat);
        int d0;
        int st;
        int n;
        d0 = done1;
        push1();
        start = 1'b1;
        st = cyc;
        tick();
        start = 1'b0;
        chk("busy1_after_start", int'(busy), 1);
        n = 0;
        while (done1 == d0 && n < 4000) begin
            if (rnd) sready = 1'($urandom_range(0, 1));
            start = (repulse && (n == 40 || n == 150)) ? 1'b1 : 1'b0;
            tick();
            n++;
        end
        sready = 1'b1;
        start = 1'b0;
        chk("done1_seen", int'(done1 != d0), 1);
        if (lat) chk("done1_latency", done_cyc1 - st, 321);
        repeat (4) tick();
        chk("done1_pulses", done1 - d0, 1);
        chk("busy1_idle", int'(busy), 0);
        chk("sb1_drained", sb1.size(), 0);
    endtask

    task automatic run2();
        int d0;
        int st;
        int n;
        d0 = done2n;
        push2();
        start2 = 1'b1;
        st = cyc;
        tick();
        start2 = 1'b0;
        chk("busy2_after_start", int'(busy2), 1);
        n = 0;
        while (done2n == d0 && n < 2000) begin
            tick();
            n++;
        end
        chk("done2_seen", int'(done2n != d0), 1);
        chk("done2_latency", done_cyc2 - st, 241);
        repeat (4) tick();
        chk("done2_pulses", done2n - d0, 1);
        chk("busy2_idle", int'(busy2), 0);
        chk("sb2_drained", sb2.size(), 0);
    endtask

    task automatic reset_mid();
        int n;
        int b0;
        push1();
        b0 = bits1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (bits1 - b0 < 71 && n < 1000) begin
            tick();
            n++;
        end
        chk("reach_f3_d5", bits1 - b0, 71);
        rst = 1'b1;
        #1;
        chk("midrst_sen", int'(sen), 1);
        chk("midrst_sd", int'(sd), 0);
        chk("midrst_busy", int'(busy), 0);
        sb1.delete();
        repeat (3) tick();
        rst = 1'b0;
        b0 = bits1;
        repeat (40) tick();
        chk("no_bits_after_rst", bits1 - b0, 0);
        chk("busy_after_rst", int'(busy), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DP; i++) bank[i] = DW'(i);
        for (int i = 0; i < DP2; i++) bank2[i] = 16'h0001;
        repeat (2) tick();
        chk("rst_sen", int'(sen), 1);
        chk("rst_sd", int'(sd), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rb_rw", int'(rb_rw), 1);
        chk("rst_rb_a", int'(rb_a), 0);
        chk("rst_sen2", int'(sen2), 1);
        rst = 1'b0;
        tick();
        run1(1'b0, 1'b0, 1'b1);
        run2();
        bank2[0] = 16'h8001;
        bank2[1] = 16'h1234;
        bank2[2] = 16'hFFFF;
        bank2[3] = 16'h0000;
        bank2[4] = 16'hA5C3;
        run2();
        run1(1'b1, 1'b0, 1'b0);
        run1(1'b0, 1'b1, 1'b1);
        reset_mid();
        run1(1'b0, 1'b0, 1'b1);
        chk("max_addr2", maxa2, 4);
        chk("rb_rw_end", int'(rb_rw), 1);
        chk("rb_a_idle", int'(rb_a), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
